// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path (and the matching receiver):
// parity encodings, FSM state type and constant helpers.
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_e;

    function automatic logic [29:0] baud_cnt_max(input logic [29:0] clk, input logic [29:0] bps);
        return clk / bps;
    endfunction

    // Data is zero-extended to 9 bits, which leaves the XOR reduction unchanged.
    function automatic logic parity_bit(input logic [8:0] data, input int mode);
        logic ones;
        ones = ^data;
        case (mode)
            PAR_ODD:  return ~ones;
            PAR_EVEN: return ones;
            default:  return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Word buffer in front of the serialiser: synchronous FIFO with count-based
// full/empty and naturally wrapping pointers.
module uart_tx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      count_r;
    logic             wr_ok_s;
    logic             rd_ok_s;

    assign full    = (count_r == (AW+1)'(DEPTH));
    assign empty   = (count_r == (AW+1)'(0));
    assign count   = count_r;
    assign rd_data = mem_r[rd_ptr_r];

    // A write while full is dropped even if a pop happens in the same cycle.
    assign wr_ok_s = wr_en && !full;
    assign rd_ok_s = rd_en && !empty;

    // Storage array; contents need no reset since count gates every read.
    always_ff @(posedge clk) begin
        if (wr_ok_s) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

    // Pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (wr_ok_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (rd_ok_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({wr_ok_s, rd_ok_s})
                2'b10:   count_r <= count_r + (AW+1)'(1);
                2'b01:   count_r <= count_r - (AW+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_frame.sv
// Parametrised UART transmitter: FIFO-buffered words serialised as
// start / data / optional parity / stop frames, sent back-to-back.
module uart_tx_frame
    import uart_pkg::*;
#(
    parameter logic [29:0] UART_BPS   = 30'd9600,
    parameter logic [29:0] CLK_FREQ   = 30'd50_000_000,
    parameter int          DATA_BITS  = 8,
    parameter int          PARITY     = 0,
    parameter int          STOP_BITS  = 1,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst,
    input  logic [DATA_BITS-1:0] pi_data,
    input  logic                 pi_flag,
    output logic                 po_ready,
    output logic                 po_busy,
    output logic                 po_overflow,
    output logic                 tx_wire
);

    localparam int BAUD_MAX = int'(baud_cnt_max(CLK_FREQ, UART_BPS));
    localparam int BW       = (BAUD_MAX > 1) ? $clog2(BAUD_MAX) : 1;
    localparam int CW       = $clog2(FIFO_DEPTH) + 1;

    tx_state_e            state_r, state_next_s;
    logic [BW-1:0]        baud_cnt_r, baud_next_s;
    logic [3:0]           bit_cnt_r, bit_cnt_next_s;
    logic [DATA_BITS-1:0] shift_r, shift_next_s;
    logic                 par_r, par_next_s;
    logic                 tx_r, tx_next_s;
    logic                 busy_r, busy_next_s;
    logic                 ovf_r;
    logic                 bit_end_s;
    logic                 pop_s;
    logic                 wr_ok_s;
    logic                 nonempty_next_s;
    logic [DATA_BITS-1:0] fifo_data_s;
    logic                 fifo_full_s;
    logic                 fifo_empty_s;
    logic [CW-1:0]        fifo_count_s;

    uart_tx_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (sys_clk),
        .rst_n   (sys_rst),
        .wr_en   (pi_flag),
        .wr_data (pi_data),
        .rd_en   (pop_s),
        .rd_data (fifo_data_s),
        .full    (fifo_full_s),
        .empty   (fifo_empty_s),
        .count   (fifo_count_s)
    );

    assign bit_end_s = (baud_cnt_r == BW'(BAUD_MAX - 1));
    assign wr_ok_s   = pi_flag && !fifo_full_s;

    // Busy must rise on the accepting edge, so it tracks next-cycle occupancy.
    assign nonempty_next_s = wr_ok_s || (fifo_count_s > CW'(1)) ||
                             ((fifo_count_s == CW'(1)) && !pop_s);

    // Next-state, datapath and line-level decode.
    always_comb begin
        state_next_s   = state_r;
        bit_cnt_next_s = bit_cnt_r;
        shift_next_s   = shift_r;
        par_next_s     = par_r;
        tx_next_s      = tx_r;
        pop_s          = 1'b0;
        if ((state_r == ST_IDLE) || bit_end_s) begin
            baud_next_s = '0;
        end else begin
            baud_next_s = baud_cnt_r + BW'(1);
        end
        case (state_r)
            ST_IDLE: begin
                if (!fifo_empty_s) begin
                    pop_s        = 1'b1;
                    state_next_s = ST_START;
                    shift_next_s = fifo_data_s;
                    par_next_s   = parity_bit(9'(fifo_data_s), PARITY);
                    tx_next_s    = 1'b0;
                end else begin
                    tx_next_s = 1'b1;
                end
            end
            ST_START: begin
                if (bit_end_s) begin
                    state_next_s   = ST_DATA;
                    bit_cnt_next_s = 4'd0;
                    tx_next_s      = shift_r[0];
                end else begin
                    tx_next_s = 1'b0;
                end
            end
            ST_DATA: begin
                if (bit_end_s) begin
                    if (bit_cnt_r == 4'(DATA_BITS - 1)) begin
                        bit_cnt_next_s = 4'd0;
                        if (PARITY != PAR_NONE) begin
                            state_next_s = ST_PARITY;
                            tx_next_s    = par_r;
                        end else begin
                            state_next_s = ST_STOP;
                            tx_next_s    = 1'b1;
                        end
                    end else begin
                        bit_cnt_next_s = bit_cnt_r + 4'd1;
                        shift_next_s   = shift_r >> 1;
                        tx_next_s      = shift_r[1];
                    end
                end else begin
                    tx_next_s = tx_r;
                end
            end
            ST_PARITY: begin
                if (bit_end_s) begin
                    state_next_s   = ST_STOP;
                    bit_cnt_next_s = 4'd0;
                    tx_next_s      = 1'b1;
                end else begin
                    tx_next_s = par_r;
                end
            end
            ST_STOP: begin
                if (bit_end_s && (bit_cnt_r == 4'(STOP_BITS - 1))) begin
                    if (!fifo_empty_s) begin
                        pop_s        = 1'b1;
                        state_next_s = ST_START;
                        shift_next_s = fifo_data_s;
                        par_next_s   = parity_bit(9'(fifo_data_s), PARITY);
                        tx_next_s    = 1'b0;
                    end else begin
                        state_next_s = ST_IDLE;
                        tx_next_s    = 1'b1;
                    end
                end else if (bit_end_s) begin
                    bit_cnt_next_s = bit_cnt_r + 4'd1;
                    tx_next_s      = 1'b1;
                end else begin
                    tx_next_s = 1'b1;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
                tx_next_s    = 1'b1;
            end
        endcase
        busy_next_s = (state_next_s != ST_IDLE) || nonempty_next_s;
    end

    // State and output registers; reset abandons any frame in flight.
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            state_r    <= ST_IDLE;
            baud_cnt_r <= '0;
            bit_cnt_r  <= 4'd0;
            shift_r    <= '0;
            par_r      <= 1'b0;
            tx_r       <= 1'b1;
            busy_r     <= 1'b0;
            ovf_r      <= 1'b0;
        end else begin
            state_r    <= state_next_s;
            baud_cnt_r <= baud_next_s;
            bit_cnt_r  <= bit_cnt_next_s;
            shift_r    <= shift_next_s;
            par_r      <= par_next_s;
            tx_r       <= tx_next_s;
            busy_r     <= busy_next_s;
            ovf_r      <= pi_flag && fifo_full_s;
        end
    end

    assign tx_wire     = tx_r;
    assign po_busy     = busy_r;
    assign po_overflow = ovf_r;
    assign po_ready    = !fifo_full_s;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed bench for uart_tx_frame: 8N1, 7O2 and 8E1 instances at 10 cycles
// per bit, checked cycle-exactly against hand-computed line patterns.
module tb_uart_tx_frame;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       sys_rst;
    logic [7:0] data_a, data_c;
    logic [6:0] data_b;
    logic       flag_a, flag_b, flag_c;
    logic       ready_a, busy_a, ovf_a, tx_a;
    logic       ready_b, busy_b, ovf_b, tx_b;
    logic       ready_c, busy_c, ovf_c, tx_c;

    int         n_checks = 0;
    int         n_errors = 0;
    int         sel;
    logic       tx_mon;
    logic       mon_en;
    logic [7:0] rx_q[$];

    assign tx_mon = (sel == 0) ? tx_a : ((sel == 1) ? tx_b : tx_c);

    uart_tx_frame #(.UART_BPS(30'd100_000), .CLK_FREQ(30'd1_000_000), .DATA_BITS(8),
                    .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u_8n1 (
        .sys_clk(clk), .sys_rst(sys_rst), .pi_data(data_a), .pi_flag(flag_a),
        .po_ready(ready_a), .po_busy(busy_a), .po_overflow(ovf_a), .tx_wire(tx_a));

    uart_tx_frame #(.UART_BPS(30'd100_000), .CLK_FREQ(30'd1_000_000), .DATA_BITS(7),
                    .PARITY(1), .STOP_BITS(2), .FIFO_DEPTH(4)) u_7o2 (
        .sys_clk(clk), .sys_rst(sys_rst), .pi_data(data_b), .pi_flag(flag_b),
        .po_ready(ready_b), .po_busy(busy_b), .po_overflow(ovf_b), .tx_wire(tx_b));

    uart_tx_frame #(.UART_BPS(30'd100_000), .CLK_FREQ(30'd1_000_000), .DATA_BITS(8),
                    .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) u_8e1 (
        .sys_clk(clk), .sys_rst(sys_rst), .pi_data(data_c), .pi_flag(flag_c),
        .po_ready(ready_c), .po_busy(busy_c), .po_overflow(ovf_c), .tx_wire(tx_c));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called at the negedge before the first start cycle; checks first and last
    // cycle of every bit, so each bit must last exactly 10 cycles.
    task automatic check_frame(input string tag, input logic [15:0] bits, input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            check($sformatf("%s_b%0d_first", tag, k), tx_mon, bits[k]);
            repeat (8) @(negedge clk);
            @(negedge clk);
            check($sformatf("%s_b%0d_last", tag, k), tx_mon, bits[k]);
        end
    endtask

    // Line monitor for the 8N1 instance: samples mid-bit, queues decoded words.
    initial begin
        logic [7:0] w;
        forever begin
            @(negedge clk);
            if (mon_en && tx_a == 1'b0) begin
                repeat (4) @(negedge clk);
                if (tx_a == 1'b0) begin
                    for (int i = 0; i < 8; i++) begin
                        repeat (10) @(negedge clk);
                        w[i] = tx_a;
                    end
                    repeat (10) @(negedge clk);
                    if (tx_a == 1'b1) rx_q.push_back(w);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int bad;
        sys_rst = 1'b0;
        flag_a = 1'b0; flag_b = 1'b0; flag_c = 1'b0;
        data_a = 8'h00; data_b = 7'h00; data_c = 8'h00;
        sel = 0; mon_en = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_tx_a", tx_a, 1);
        check("rst_ready_a", ready_a, 1);
        check("rst_busy_a", busy_a, 0);
        check("rst_ovf_a", ovf_a, 0);
        check("rst_tx_b", tx_b, 1);
        check("rst_tx_c", tx_c, 1);
        sys_rst = 1'b1;
        @(negedge clk);
        mon_en = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_tx_a", tx_a, 1);
        check("idle_busy_a", busy_a, 0);

        // 8N1, 8'hA5 -> 0,1,0,1,0,0,1,0,1,1
        sel = 0;
        @(negedge clk); flag_a = 1'b1; data_a = 8'hA5;
        @(negedge clk); flag_a = 1'b0;
        check("8n1_busy_rise", busy_a, 1);
        check("8n1_tx_before_fall", tx_a, 1);
        check_frame("8n1", 16'h034A, 10);
        check("8n1_busy_last_cycle", busy_a, 1);
        @(negedge clk);
        check("8n1_busy_fall", busy_a, 0);
        check("8n1_tx_idle", tx_a, 1);

        // 7O2, 7'h03 -> 0,1,1,0,0,0,0,0,1,1,1
        repeat (3) @(negedge clk);
        sel = 1;
        @(negedge clk); flag_b = 1'b1; data_b = 7'h03;
        @(negedge clk); flag_b = 1'b0;
        check("7o2_busy_rise", busy_b, 1);
        check_frame("7o2", 16'h0706, 11);
        @(negedge clk);
        check("7o2_busy_fall", busy_b, 0);
        check("7o2_tx_idle", tx_b, 1);

        // 8E1, 8'h07 -> parity 1; 8'h03 -> parity 0
        repeat (3) @(negedge clk);
        sel = 2;
        @(negedge clk); flag_c = 1'b1; data_c = 8'h07;
        @(negedge clk); flag_c = 1'b0;
        check_frame("8e1_07", 16'h060E, 11);
        @(negedge clk);
        check("8e1_busy_fall_07", busy_c, 0);
        repeat (3) @(negedge clk);
        @(negedge clk); flag_c = 1'b1; data_c = 8'h03;
        @(negedge clk); flag_c = 1'b0;
        check_frame("8e1_03", 16'h0406, 11);
        @(negedge clk);
        check("8e1_busy_fall_03", busy_c, 0);

        // Back-to-back 11, 22, 33 on consecutive cycles
        repeat (3) @(negedge clk);
        sel = 0;
        @(negedge clk); flag_a = 1'b1; data_a = 8'h11;
        @(negedge clk); data_a = 8'h22;
        fork
            begin
                @(negedge clk); data_a = 8'h33;
                @(negedge clk); flag_a = 1'b0;
            end
        join_none
        check_frame("b2b_11", 16'h0222, 10);
        check_frame("b2b_22", 16'h0244, 10);
        check_frame("b2b_33", 16'h0266, 10);
        @(negedge clk);
        check("b2b_busy_fall", busy_a, 0);

        // Overflow: 6 strobes, 5 accepted, 6th dropped
        repeat (5) @(negedge clk);
        rx_q.delete();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i == 4) check("ovf_ready_before_5th", ready_a, 1);
            if (i == 5) begin
                check("ovf_ready_full", ready_a, 0);
                check("ovf_no_pulse_yet", ovf_a, 0);
            end
            flag_a = 1'b1;
            data_a = 8'(8'h41 + i);
        end
        @(negedge clk); flag_a = 1'b0;
        check("ovf_pulse", ovf_a, 1);
        check("ovf_ready_still_full", ready_a, 0);
        @(negedge clk);
        check("ovf_pulse_one_cycle", ovf_a, 0);
        for (int i = 0; i < 1000 && busy_a; i++) @(negedge clk);
        check("ovf_drain_busy", busy_a, 0);
        repeat (20) @(negedge clk);
        check("ovf_word_count", rx_q.size(), 5);
        for (int i = 0; i < rx_q.size() && i < 5; i++)
            check($sformatf("ovf_word%0d", i), rx_q[i], 8'(8'h41 + i));

        // Reset during data bit 3 with two words queued
        repeat (5) @(negedge clk);
        @(negedge clk); flag_a = 1'b1; data_a = 8'h55;
        @(negedge clk); data_a = 8'h66;
        @(negedge clk); data_a = 8'h77;
        @(negedge clk); flag_a = 1'b0;
        repeat (43) @(negedge clk);
        check("rst_mid_tx_low", tx_a, 0);
        check("rst_mid_busy", busy_a, 1);
        #2 sys_rst = 1'b0;
        #1;
        check("rst_async_tx", tx_a, 1);
        check("rst_async_busy", busy_a, 0);
        check("rst_async_ready", ready_a, 1);
        repeat (3) @(negedge clk);
        sys_rst = 1'b1;
        bad = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (tx_a !== 1'b1 || busy_a !== 1'b0) bad++;
        end
        check("rst_line_stays_idle", bad, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_frame.md
# uart_tx_frame

Parametrised UART transmitter, the next generation of our fixed 8N1 serial transmitter. It takes parallel words through a strobe/ready handshake and buffers them in a small FIFO. Each word is serialised as an asynchronous frame with configurable data width, parity and stop-bit count, and frames go out back-to-back with no idle gap while the FIFO holds data. It sits between the on-board control/data logic and the UART pin, on the single system clock.

## Interface
- `UART_BPS`, default 30'd9600: line baud rate.
- `CLK_FREQ`, default 30'd50_000_000: `sys_clk` frequency in Hz.
- `DATA_BITS`, default 8: data bits per frame; legal range 5..9.
- `PARITY`, default 0: 0 = none, 1 = odd, 2 = even.
- `STOP_BITS`, default 1: legal values 1 or 2.
- `FIFO_DEPTH`, default 4: word buffer depth; power of two, ≥2.
- `sys_clk`  input  1  system clock; the only clock.
- `sys_rst`  input  1  reset; asynchronous, active-low.
- `pi_data`  input  DATA_BITS  word to send; sampled when `pi_flag`=1.
- `pi_flag`  input  1  one-cycle write strobe.
- `po_ready`  output  1  FIFO not full; a write is accepted only when it is 1.
- `po_busy`  output  1  a frame is on the line or the FIFO is non-empty.
- `po_overflow`  output  1  one-cycle pulse when `pi_flag`=1 and `po_ready`=0; the word is dropped.
- `tx_wire`  output  1  serial line; idles high.

## Operation
- Bit period: `BAUD_CNT_MAX = CLK_FREQ/UART_BPS` cycles, integer-truncated. The baud counter runs 0..BAUD_CNT_MAX-1 only outside IDLE. Every bit, including start, parity and each stop bit, is held for exactly BAUD_CNT_MAX cycles.
- Frame layout, LSB first: start (0), `DATA_BITS` data bits, optional parity bit, `STOP_BITS` stop bits (1).
- Parity is computed over the popped word.
  - Odd parity: the count of ones across data plus parity is odd.
  - Even parity: that count is even.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE → START when the FIFO is non-empty. On that edge the word is popped into the shift register and `tx_wire` goes to 0.
  - START → DATA at the end of its bit period.
  - DATA → PARITY after bit DATA_BITS-1. If `PARITY`=0, DATA → STOP instead.
  - PARITY → STOP at the end of its bit period.
  - STOP → START on the last cycle of the last stop bit if the FIFO is non-empty; the word is popped on that same edge. Otherwise STOP → IDLE.
- FIFO rules:
  - A write is accepted iff `pi_flag`=1 and `po_ready`=1.
  - `po_ready` = !full, taken from the registered occupancy count.
  - A write while full is dropped even if a pop happens in the same cycle.
  - A simultaneous write and pop on a non-full, non-empty FIFO leaves the occupancy unchanged.
  - Read and write pointers are log2(FIFO_DEPTH) bits, wrap naturally, and use a separate count for full/empty.
- Reset (asserted at any time, including mid-frame):
  - `tx_wire`=1, `po_ready`=1, `po_busy`=0, `po_overflow`=0, FSM=IDLE.
  - FIFO emptied and all counters cleared.
  - A partially sent frame is abandoned and not resent.

## Timing
- Write accepted at edge N. The FIFO is non-empty after N, and `tx_wire` falls at edge N+1.
- Frame length is (1 + DATA_BITS + (PARITY!=0) + STOP_BITS) × BAUD_CNT_MAX cycles.
- Back-to-back frames: the next start bit begins on the cycle immediately after the final stop-bit cycle, with zero idle cycles.
- `po_busy` rises at edge N, together with the FIFO becoming non-empty. It falls on the edge where STOP → IDLE.
- `po_overflow` is registered; it is high for the one cycle after the rejected strobe.
- `tx_wire` is driven directly from a flop; no combinational path from inputs.

## Structure
- Shared package `uart_pkg` holds:
  - parity encodings `PAR_NONE`/`PAR_ODD`/`PAR_EVEN`;
  - the FSM state typedef;
  - a `baud_cnt_max(clk, bps)` constant function, reused by the future matching receiver.
- One sub-module, `uart_tx_fifo`: synchronous FIFO with `DATA_BITS` width, `FIFO_DEPTH` depth, count-based full/empty, same clock and reset.
- Top level contains the FSM, baud counter, bit counter, shift register and parity generator.

## Test plan
Directed tests use CLK_FREQ=1_000_000 and UART_BPS=100_000, i.e. 10 cycles per bit.

- **8N1:** write 8'hA5 → line shows 0,1,0,1,0,0,1,0,1,1 (start, LSB first, stop), 10 cycles per bit. `tx_wire` falls 1 cycle after the accepting edge. `po_busy` drops after 100 cycles.
- **7O2 (DATA_BITS=7, PARITY=1, STOP_BITS=2):** write 7'h03 → data bits 1,1,0,0,0,0,0, then parity 1, then two stop bits. Frame is 110 cycles.
- **8E1:** write 8'h07 → parity bit 1. Write 8'h03 → parity bit 0.
- **Back-to-back:** write 8'h11, 8'h22, 8'h33 on consecutive cycles → three contiguous frames. The stop bit is followed immediately by a start bit, with no high cycle beyond the stop period.
- **Overflow (FIFO_DEPTH=4):** issue 6 strobes on consecutive cycles.
  - The first word pops at once, so 5 words are accepted.
  - `po_ready` is 0 from the cycle after the 5th accept.
  - The 6th strobe → one `po_overflow` pulse, and that word never appears on the line.
- **Reset mid-frame:** assert `sys_rst` during data bit 3 with 2 words queued → `tx_wire`=1 immediately, without waiting for a clock edge. After release the line stays idle and `po_busy`=0.
